// File: rtl/board_draw_sequencer.sv
// -----------------------------------------------------------------------------
// board_draw_sequencer
//
// Walks the 8x8 Othello board in raster order and issues one draw request per
// square to a downstream 12x12 sprite plotter, then optionally draws the cursor
// sprite as a final overlay pass. The board and cursor are snapshotted when a
// redraw starts, so game-state changes mid-redraw do not tear the picture.
//
// Ports
//   clock        in   1    system clock, all state on rising edge
//   resetn       in   1    asynchronous active-low reset
//   start        in   1    request a full redraw (sampled only when idle)
//   board        in   128  cell i = board[2i+1:2i], i = row*8+col
//   cursor_row   in   3    cursor row 0..7
//   cursor_col   in   3    cursor column 0..7
//   cursor_en    in   1    draw the cursor overlay after the 64 cells
//   plot_x       out  8    sprite origin x
//   plot_y       out  7    sprite origin y
//   plot_select  out  2    0 empty, 1 black, 2 cursor, 3 white
//   plot_enable  out  1    one-cycle draw request pulse
//   busy         out  1    high while a redraw is in progress
//   done         out  1    one-cycle pulse when a redraw completes
// -----------------------------------------------------------------------------
module board_draw_sequencer #(
    parameter int CELL        = 12,
    parameter int ORIGIN_X    = 32,
    parameter int ORIGIN_Y    = 12,
    parameter int DRAW_CYCLES = 152
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [127:0] board,
    input  logic [2:0]   cursor_row,
    input  logic [2:0]   cursor_col,
    input  logic         cursor_en,
    output logic [7:0]   plot_x,
    output logic [6:0]   plot_y,
    output logic [1:0]   plot_select,
    output logic         plot_enable,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Cell code to sprite: 10 is an unused encoding and draws as empty.
    function automatic logic [1:0] cell_sprite(input logic [1:0] code);
        logic [1:0] sel;
        case (code)
            2'b01:   sel = 2'd1;
            2'b11:   sel = 2'd3;
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

    function automatic logic [7:0] col_to_x(input logic [2:0] col);
        return 8'(ORIGIN_X + int'(col) * CELL);
    endfunction

    function automatic logic [6:0] row_to_y(input logic [2:0] row);
        return 7'(ORIGIN_Y + int'(row) * CELL);
    endfunction

    state_t           state_q,   state_d;
    logic [6:0]       index_q,   index_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [127:0]     board_q,   board_d;
    logic [2:0]       crow_q,    crow_d;
    logic [2:0]       ccol_q,    ccol_d;
    logic             cen_q,     cen_d;
    logic [7:0]       plot_x_q,  plot_x_d;
    logic [6:0]       plot_y_q,  plot_y_d;
    logic [1:0]       plot_sel_q, plot_sel_d;
    logic             plot_en_q, plot_en_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             load_draw_s;

    // Next-state, snapshot and registered-output computation.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        board_d     = board_q;
        crow_d      = crow_q;
        ccol_d      = ccol_q;
        cen_d       = cen_q;
        plot_x_d    = plot_x_q;
        plot_y_d    = plot_y_q;
        plot_sel_d  = plot_sel_q;
        plot_en_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        load_draw_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    board_d     = board;
                    crow_d      = cursor_row;
                    ccol_d      = cursor_col;
                    cen_d       = cursor_en;
                    index_d     = 7'd0;
                    state_d     = S_ISSUE;
                    plot_en_d   = 1'b1;
                    busy_d      = 1'b1;
                    load_draw_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = {CNT_W{1'b0}};
                busy_d  = 1'b1;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    // Index 64 is the cursor pass, reached only when enabled.
                    if ((index_q < 7'd63) || ((index_q == 7'd63) && cen_q)) begin
                        index_d     = index_q + 7'd1;
                        state_d     = S_ISSUE;
                        plot_en_d   = 1'b1;
                        busy_d      = 1'b1;
                        load_draw_s = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Origin/select are loaded on the edge entering ISSUE and then held.
        // board_d is used so the very first draw sees the fresh snapshot.
        if (load_draw_s) begin
            if (index_d[6]) begin
                plot_x_d   = col_to_x(ccol_d);
                plot_y_d   = row_to_y(crow_d);
                plot_sel_d = 2'd2;
            end else begin
                plot_x_d   = col_to_x(index_d[2:0]);
                plot_y_d   = row_to_y(index_d[5:3]);
                plot_sel_d = cell_sprite(board_d[{index_d[5:0], 1'b0} +: 2]);
            end
        end else begin
            plot_x_d   = plot_x_q;
            plot_y_d   = plot_y_q;
            plot_sel_d = plot_sel_q;
        end
    end

    // Sequencer state, snapshot and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            index_q    <= 7'd0;
            cnt_q      <= {CNT_W{1'b0}};
            board_q    <= 128'd0;
            crow_q     <= 3'd0;
            ccol_q     <= 3'd0;
            cen_q      <= 1'b0;
            plot_x_q   <= 8'd0;
            plot_y_q   <= 7'd0;
            plot_sel_q <= 2'd0;
            plot_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            cnt_q      <= cnt_d;
            board_q    <= board_d;
            crow_q     <= crow_d;
            ccol_q     <= ccol_d;
            cen_q      <= cen_d;
            plot_x_q   <= plot_x_d;
            plot_y_q   <= plot_y_d;
            plot_sel_q <= plot_sel_d;
            plot_en_q  <= plot_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_select = plot_sel_q;
    assign plot_enable = plot_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_board_draw_sequencer
//
// Table of full redraw scenarios with hand-computed probe draws, pulse counts
// and completion cycles, plus hand-written sequences for start/board changes
// mid-redraw, start held high across DONE, and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_board_draw_sequencer;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [127:0] board;
    logic [2:0]   cursor_row;
    logic [2:0]   cursor_col;
    logic         cursor_en;
    logic [7:0]   plot_x;
    logic [6:0]   plot_y;
    logic [1:0]   plot_select;
    logic         plot_enable;
    logic         busy;
    logic         done;

    board_draw_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .board       (board),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .cursor_en   (cursor_en),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_select (plot_select),
        .plot_enable (plot_enable),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- monitor: logs every pulse and done ----------------
    int         edge_cnt = 0;
    int         pulse_n  = 0;
    int         done_n   = 0;
    int         stab_err = 0;
    int         pulse_cyc [0:1023];
    logic [7:0] pulse_x   [0:1023];
    logic [6:0] pulse_y   [0:1023];
    logic [1:0] pulse_s   [0:1023];
    int         done_cyc  [0:63];
    logic [7:0] last_x = 8'd0;
    logic [6:0] last_y = 7'd0;
    logic [1:0] last_s = 2'd0;
    logic       prev_en = 1'b0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    always @(negedge clock) begin
        if (resetn) begin
            if (plot_enable) begin
                if (pulse_n < 1024) begin
                    pulse_cyc[pulse_n] <= edge_cnt;
                    pulse_x[pulse_n]   <= plot_x;
                    pulse_y[pulse_n]   <= plot_y;
                    pulse_s[pulse_n]   <= plot_select;
                end
                pulse_n <= pulse_n + 1;
                last_x  <= plot_x;
                last_y  <= plot_y;
                last_s  <= plot_select;
                if (prev_en) stab_err <= stab_err + 1;
            end else if (busy) begin
                if (plot_x != last_x || plot_y != last_y || plot_select != last_s)
                    stab_err <= stab_err + 1;
            end
            if (done) begin
                if (done_n < 64) done_cyc[done_n] <= edge_cnt;
                done_n <= done_n + 1;
            end
            prev_en <= plot_enable;
        end else begin
            prev_en <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    function automatic void exp_draw(input logic [127:0] b, input logic [2:0] cr,
                                     input logic [2:0] cc, input int k,
                                     output int x, output int y, output int s);
        logic [1:0] code;
        int r, c;
        if (k == 64) begin
            r = int'(cr); c = int'(cc); s = 2;
        end else begin
            r = k / 8; c = k % 8;
            code = b[2*k +: 2];
            s = (code == 2'b01) ? 1 : ((code == 2'b11) ? 3 : 0);
        end
        x = 32 + c * 12;
        y = 12 + r * 12;
    endfunction

    // Pulses start for one cycle around edge 0; base is set so cycle 1 == 1.
    task automatic begin_redraw(input logic [127:0] b, input logic [2:0] cr,
                                input logic [2:0] cc, input logic ce,
                                output int base, output int pb, output int db);
        tick();
        board = b; cursor_row = cr; cursor_col = cc; cursor_en = ce;
        start = 1'b1;
        pb = pulse_n; db = done_n;
        @(negedge clock);
        start = 1'b0;
        base = edge_cnt - 1;
        #1;
    endtask

    task automatic finish_redraw(input string tag, input logic [127:0] b,
                                 input logic [2:0] cr, input logic [2:0] cc,
                                 input int base, input int pb, input int db,
                                 input int exp_pulses, input int exp_done);
        int x, y, s, np;
        bit timed_out;
        timed_out = 1'b1;
        for (int c = 0; c < 11000; c++) begin
            tick();
            if (done_n != db) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk({tag, " done_timeout"}, int'(timed_out), 0);
        repeat (5) tick();
        chk({tag, " done_count"}, done_n - db, 1);
        chk({tag, " done_cycle"}, done_cyc[db] - base, exp_done);
        chk({tag, " busy_after"}, int'(busy), 0);
        np = pulse_n - pb;
        chk({tag, " pulse_count"}, np, exp_pulses);
        if (np > 65) np = 65;
        for (int k = 0; k < np; k++) begin
            exp_draw(b, cr, cc, k, x, y, s);
            chk({tag, " pulse_cycle"}, pulse_cyc[pb+k] - base, 1 + k * 153);
            chk({tag, " pulse_x"}, int'(pulse_x[pb+k]), x);
            chk({tag, " pulse_y"}, int'(pulse_y[pb+k]), y);
            chk({tag, " pulse_sel"}, int'(pulse_s[pb+k]), s);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [6:0] idx;
        logic [7:0] x;
        logic [6:0] y;
        logic [1:0] sel;
    } probe_t;

    typedef struct {
        logic [127:0] b;
        logic [2:0]   cr;
        logic [2:0]   cc;
        logic         ce;
        int           exp_pulses;
        int           exp_done;
        probe_t       p0, p1, p2, p3;
    } vec_t;

    localparam logic [127:0] BOARD_MIX = 128'hC000_0000_0000_0000_0100_0000_0000_0008;

    vec_t vecs [0:2];

    initial begin
        int base, pb, db;
        probe_t pr [0:3];
        logic [127:0] b0;

        resetn = 1'b0; start = 1'b0; board = 128'd0;
        cursor_row = 3'd0; cursor_col = 3'd0; cursor_en = 1'b0;

        vecs[0] = '{b: 128'd0, cr: 3'd0, cc: 3'd0, ce: 1'b1, exp_pulses: 65, exp_done: 9946,
                    p0: '{7'd0,  8'd32,  7'd12, 2'd0}, p1: '{7'd9,  8'd44, 7'd24, 2'd0},
                    p2: '{7'd63, 8'd116, 7'd96, 2'd0}, p3: '{7'd64, 8'd32, 7'd12, 2'd2}};
        vecs[1] = '{b: BOARD_MIX, cr: 3'd2, cc: 3'd5, ce: 1'b1, exp_pulses: 65, exp_done: 9946,
                    p0: '{7'd28, 8'd80,  7'd48, 2'd1}, p1: '{7'd63, 8'd116, 7'd96, 2'd3},
                    p2: '{7'd1,  8'd44,  7'd12, 2'd0}, p3: '{7'd64, 8'd92,  7'd36, 2'd2}};
        vecs[2] = '{b: BOARD_MIX, cr: 3'd2, cc: 3'd5, ce: 1'b0, exp_pulses: 64, exp_done: 9793,
                    p0: '{7'd28, 8'd80,  7'd48, 2'd1}, p1: '{7'd63, 8'd116, 7'd96, 2'd3},
                    p2: '{7'd1,  8'd44,  7'd12, 2'd0}, p3: '{7'd0,  8'd32,  7'd12, 2'd0}};

        // Reset state.
        repeat (3) tick();
        chk("reset plot_x", int'(plot_x), 0);
        chk("reset plot_y", int'(plot_y), 0);
        chk("reset plot_select", int'(plot_select), 0);
        chk("reset plot_enable", int'(plot_enable), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        tick();
        resetn = 1'b1;
        repeat (2) tick();

        // Table-driven full redraws.
        for (int v = 0; v < 3; v++) begin
            begin_redraw(vecs[v].b, vecs[v].cr, vecs[v].cc, vecs[v].ce, base, pb, db);
            chk("first busy", int'(busy), 1);
            pr[0] = vecs[v].p0; pr[1] = vecs[v].p1; pr[2] = vecs[v].p2; pr[3] = vecs[v].p3;
            finish_redraw($sformatf("vec%0d", v), vecs[v].b, vecs[v].cr, vecs[v].cc,
                          base, pb, db, vecs[v].exp_pulses, vecs[v].exp_done);
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("vec%0d probe%0d x", v, p), int'(pulse_x[pb + int'(pr[p].idx)]), int'(pr[p].x));
                chk($sformatf("vec%0d probe%0d y", v, p), int'(pulse_y[pb + int'(pr[p].idx)]), int'(pr[p].y));
                chk($sformatf("vec%0d probe%0d sel", v, p), int'(pulse_s[pb + int'(pr[p].idx)]), int'(pr[p].sel));
            end
        end

        // Inputs change and start pulses mid-redraw: snapshot must win.
        b0 = BOARD_MIX;
        begin_redraw(b0, 3'd4, 3'd1, 1'b0, base, pb, db);
        while (edge_cnt - base < 499) tick();
        board = ~b0; cursor_en = 1'b1; cursor_row = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        finish_redraw("midrun", b0, 3'd4, 3'd1, base, pb, db, 64, 9793);

        // Start held high: next redraw begins right after DONE.
        begin_redraw(128'd0, 3'd0, 3'd0, 1'b0, base, pb, db);
        start = 1'b1;
        for (int c = 0; c < 11000 && done_n == db; c++) tick();
        chk("held done_seen", done_n - db, 1);
        chk("held done_cycle", done_cyc[db] - base, 9793);
        for (int c = 0; c < 10 && pulse_n - pb < 65; c++) tick();
        chk("held restart_pulses", pulse_n - pb, 65);
        chk("held restart_gap", pulse_cyc[pb+64] - done_cyc[db], 2);
        chk("held restart_x", int'(pulse_x[pb+64]), 32);
        chk("held restart_y", int'(pulse_y[pb+64]), 12);
        start = 1'b0;

        // Async reset mid-run: outputs clear within the cycle, no done pulse.
        repeat (300) tick();
        db = done_n;
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("abort plot_x", int'(plot_x), 0);
        chk("abort plot_y", int'(plot_y), 0);
        chk("abort plot_select", int'(plot_select), 0);
        chk("abort plot_enable", int'(plot_enable), 0);
        chk("abort busy", int'(busy), 0);
        repeat (3) tick();
        resetn = 1'b1;
        pb = pulse_n;
        repeat (20) tick();
        chk("abort no_done", done_n - db, 0);
        chk("abort no_pulse", pulse_n - pb, 0);
        chk("abort idle_busy", int'(busy), 0);

        // Restart after abort begins at index 0.
        begin_redraw(BOARD_MIX, 3'd0, 3'd0, 1'b0, base, pb, db);
        chk("restart pulse", pulse_n - pb, 1);
        chk("restart x", int'(pulse_x[pb]), 32);
        chk("restart y", int'(pulse_y[pb]), 12);
        repeat (160) tick();
        chk("restart second_x", int'(pulse_x[pb+1]), 44);
        chk("restart second_sel", int'(pulse_s[pb+1]), 0);

        chk("wait_window_stability", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
